// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the intersection controller and its front-end
//   conditioners: the vehicle-detector FSM state encoding, default timing
//   constants and the lamp encoding driven by the controller.
//   No ports (package).
// -----------------------------------------------------------------------------
package traffic_pkg;

    // Vehicle-detector demand FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEMAND = 2'd1,
        HOLD   = 2'd2
    } veh_state_e;

    // Default timing constants, in clock edges.
    localparam int DEB_CYCLES_DEF   = 3;
    localparam int HOLD_CYCLES_DEF  = 5;
    localparam int STUCK_CYCLES_DEF = 200;

    // Lamp encoding used by the intersection controller.
    typedef enum logic [1:0] {
        LAMP_GREEN  = 2'd0,
        LAMP_YELLOW = 2'd1,
        LAMP_RED    = 2'd2
    } lamp_e;

endpackage

// File: rtl/det_debounce.sv
// -----------------------------------------------------------------------------
// det_debounce
//   Two-flop synchroniser followed by a mismatch-run debouncer. The debounced
//   level flips after DEB_CYCLES consecutive synchronised samples disagree
//   with it; any agreeing sample restarts the run.
//
//   Ports:
//     Clk    in   system clock, rising edge
//     reset  in   synchronous, active-low reset
//     din    in   raw asynchronous input
//     dout   out  debounced level that is registered on the coming edge
//                 (decoded only from flops). Downstream logic registers it
//                 and compares against its own copy to see rises/falls on
//                 the very edge they happen.
// -----------------------------------------------------------------------------
module det_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF   // 1..15
) (
    input  logic Clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = 4;

    logic          s1_q;
    logic          det_s_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (det_s_q != level_q) begin
            // This edge completes the run of DEB_CYCLES disagreeing samples.
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            det_s_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= din;
            det_s_q <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = level_d;

endmodule

// File: rtl/veh_detector.sv
// -----------------------------------------------------------------------------
// veh_detector
//   Side-road vehicle-detector conditioner feeding the intersection
//   controller's car-waiting input. Synchronises and debounces the loop
//   signal, stretches demand across short gaps between vehicles and counts
//   arrivals since the side road was last served.
//
//   Ports:
//     Clk       in   system clock, rising edge
//     reset     in   synchronous, active-low reset
//     det_raw   in   raw inductive-loop signal, asynchronous to Clk
//     SG        in   side-road green; clears the arrival count
//     C         out  registered car demand to the controller
//     presence  out  registered debounced vehicle presence
//     arrivals  out  saturating arrival count [CNT_W]
//     stuck     out  stuck-on loop fault (constant 0 unless VEH_DET_STUCK_EN)
//
//   Build option: define VEH_DET_STUCK_EN to add the stuck-on fault
//   detector (forces C high and freezes arrivals once tripped).
// -----------------------------------------------------------------------------
module veh_detector
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,    // 1..15
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,   // 1..255
    parameter int CNT_W        = 8,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             det_raw,
    input  logic             SG,
    output logic             C,
    output logic             presence,
    output logic [CNT_W-1:0] arrivals,
    output logic             stuck
);

    logic             presence_nxt;
    logic             presence_q;
    logic             rise, fall;
    veh_state_e       state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [CNT_W-1:0] arrivals_q, arrivals_d;
    logic             c_q, c_d;

    det_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .Clk   (Clk),
        .reset (reset),
        .din   (det_raw),
        .dout  (presence_nxt)
    );

    // Edges of presence, seen on the edge where presence itself changes.
    assign rise = presence_nxt & ~presence_q;
    assign fall = ~presence_nxt & presence_q;

`ifdef VEH_DET_STUCK_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic          stuck_q, stuck_d;

    // Counts edges that leave presence high; saturates at the trip point.
    always_comb begin
        stuck_cnt_d = '0;
        if (presence_nxt) begin
            stuck_cnt_d = (stuck_cnt_q == SW'(STUCK_CYCLES)) ? stuck_cnt_q
                                                              : stuck_cnt_q + SW'(1);
        end
        stuck_d = stuck_q | (stuck_cnt_d == SW'(STUCK_CYCLES));
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            stuck_cnt_q <= '0;
            stuck_q     <= 1'b0;
        end else begin
            stuck_cnt_q <= stuck_cnt_d;
            stuck_q     <= stuck_d;
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        arrivals_d = arrivals_q;

        unique case (state_q)
            IDLE: begin
                if (rise) state_d = DEMAND;
            end
            DEMAND: begin
                if (fall) begin
                    state_d = HOLD;
                    hold_d  = 8'(HOLD_CYCLES);
                end
            end
            HOLD: begin
                // A new vehicle wins over hold expiry on the same edge.
                if (rise) begin
                    state_d = DEMAND;
                end else begin
                    hold_d = hold_q - 8'd1;
                    if (hold_d == 8'd0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear on service first, then count, so clear+arrival gives 1.
        if (SG) arrivals_d = '0;
        if (rise && (arrivals_d != '1)) arrivals_d = arrivals_d + CNT_W'(1);

`ifdef VEH_DET_STUCK_EN
        if (stuck_q) arrivals_d = arrivals_q;
        c_d = (state_d != IDLE) | stuck_d;
`else
        c_d = (state_d != IDLE);
`endif
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            presence_q <= 1'b0;
            state_q    <= IDLE;
            hold_q     <= '0;
            arrivals_q <= '0;
            c_q        <= 1'b0;
        end else begin
            presence_q <= presence_nxt;
            state_q    <= state_d;
            hold_q     <= hold_d;
            arrivals_q <= arrivals_d;
            c_q        <= c_d;
        end
    end

    assign C        = c_q;
    assign presence = presence_q;
    assign arrivals = arrivals_q;

endmodule

// File: tb/tb_veh_detector.sv
// -----------------------------------------------------------------------------
// tb_veh_detector
//   Self-checking bench for veh_detector (default build). A second instance
//   with CNT_W=2 shares the stimulus to exercise arrival saturation.
//   The reference model works from the behavioural rules: a presence level
//   that flips after DEB disagreeing synchronised samples, C = presence or
//   "a presence fall happened fewer than HOLD edges ago", and a clear-then-
//   count arrival total.
// -----------------------------------------------------------------------------
module tb_veh_detector;

    localparam int DEB    = 3;
    localparam int HOLD   = 5;
    localparam int CNT_W  = 8;
    localparam int CNT_W2 = 2;
    localparam int MAX1   = (1 << CNT_W) - 1;
    localparam int MAX2   = (1 << CNT_W2) - 1;

    logic              Clk = 1'b0;
    logic              reset = 1'b0;
    logic              det_raw = 1'b0;
    logic              SG = 1'b0;
    logic              C, presence, stuck;
    logic [CNT_W-1:0]  arrivals;
    logic              C2, presence2, stuck2;
    logic [CNT_W2-1:0] arrivals2;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit m_s1, m_ds, m_pres, m_c;
    int m_mism, m_arr, m_arr2, m_last_fall, m_edge;

    always #5 Clk = ~Clk;

    veh_detector #(
        .DEB_CYCLES (DEB), .HOLD_CYCLES (HOLD), .CNT_W (CNT_W), .STUCK_CYCLES (200)
    ) dut (
        .Clk (Clk), .reset (reset), .det_raw (det_raw), .SG (SG),
        .C (C), .presence (presence), .arrivals (arrivals), .stuck (stuck)
    );

    veh_detector #(
        .DEB_CYCLES (DEB), .HOLD_CYCLES (HOLD), .CNT_W (CNT_W2), .STUCK_CYCLES (200)
    ) dut2 (
        .Clk (Clk), .reset (reset), .det_raw (det_raw), .SG (SG),
        .C (C2), .presence (presence2), .arrivals (arrivals2), .stuck (stuck2)
    );

    task automatic model_edge(input bit raw, input bit sg, input bit rst);
        bit ds_before;
        bit rose, fell;
        if (!rst) begin
            m_s1 = 0; m_ds = 0; m_pres = 0; m_c = 0;
            m_mism = 0; m_arr = 0; m_arr2 = 0; m_last_fall = -1;
        end else begin
            ds_before = m_ds;
            m_ds = m_s1;
            m_s1 = raw;
            rose = 0;
            fell = 0;
            if (ds_before != m_pres) begin
                m_mism++;
                if (m_mism == DEB) begin
                    m_pres = !m_pres;
                    m_mism = 0;
                    if (m_pres) rose = 1; else fell = 1;
                end
            end else begin
                m_mism = 0;
            end
            if (fell) m_last_fall = m_edge;
            if (sg) begin m_arr = 0; m_arr2 = 0; end
            if (rose) begin
                m_arr  = (m_arr  >= MAX1) ? MAX1 : m_arr + 1;
                m_arr2 = (m_arr2 >= MAX2) ? MAX2 : m_arr2 + 1;
            end
            m_c = m_pres || (m_last_fall >= 0 && (m_edge - m_last_fall) < HOLD);
        end
        m_edge++;
    endtask

    // Drive one edge's inputs, wait past the edge, advance the model.
    task automatic step(input bit raw, input bit sg, input bit rst);
        @(negedge Clk);
        det_raw = raw;
        SG      = sg;
        reset   = rst;
        @(posedge Clk);
        #1;
        model_edge(raw, sg, rst);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0);
            vectors += 4;
            if (C !== 1'b0) begin miscompares++; $display("FAIL reset_C cyc%0d got %b want 0", i, C); end
            if (presence !== 1'b0) begin miscompares++; $display("FAIL reset_presence cyc%0d got %b want 0", i, presence); end
            if (arrivals !== '0) begin miscompares++; $display("FAIL reset_arrivals cyc%0d got %0d want 0", i, arrivals); end
            if (stuck !== 1'b0) begin miscompares++; $display("FAIL reset_stuck cyc%0d got %b want 0", i, stuck); end
        end
    endtask

    task automatic test_first_arrival();
        logic exp;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b1);
            exp = (i >= DEB + 1);
            vectors += 3;
            if (presence !== exp) begin miscompares++; $display("FAIL first_presence edge%0d got %b want %b", i, presence, exp); end
            if (C !== exp) begin miscompares++; $display("FAIL first_C edge%0d got %b want %b", i, C, exp); end
            if (arrivals !== CNT_W'(exp)) begin miscompares++; $display("FAIL first_arrivals edge%0d got %0d want %0d", i, arrivals, exp); end
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1);
            vectors++;
            if (C !== m_c) begin miscompares++; $display("FAIL first_release_C cyc%0d got %b want %b", i, C, m_c); end
        end
    endtask

    task automatic test_glitch();
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(i < 2, 1'b0, 1'b1);
            vectors += 3;
            if (presence !== 1'b0) begin miscompares++; $display("FAIL glitch_presence edge%0d got %b want 0", i, presence); end
            if (C !== 1'b0) begin miscompares++; $display("FAIL glitch_C edge%0d got %b want 0", i, C); end
            if (arrivals !== '0) begin miscompares++; $display("FAIL glitch_arrivals edge%0d got %0d want 0", i, arrivals); end
        end
    endtask

    // high 8, low 4, high 8, low 20: presence rises 4, falls 12, rises 16,
    // falls 24; C must stay high from 4 through 28 and drop at 29.
    task automatic test_gap();
        logic exp_c;
        int   exp_arr;
        bit   raw;
        logic prev_p, prev_c;
        int   p_fall, c_fall;
        step(1'b0, 1'b0, 1'b0);
        prev_p = 1'b0; prev_c = 1'b0; p_fall = -1; c_fall = -1;
        for (int i = 0; i < 40; i++) begin
            raw = (i < 8) || (i >= 12 && i < 20);
            step(raw, 1'b0, 1'b1);
            exp_c   = (i >= 4 && i < 4 + 20 + HOLD);
            exp_arr = (i < 4) ? 0 : (i < 16) ? 1 : 2;
            vectors += 3;
            if (C !== exp_c) begin miscompares++; $display("FAIL gap_C edge%0d got %b want %b", i, C, exp_c); end
            if (arrivals !== CNT_W'(exp_arr)) begin miscompares++; $display("FAIL gap_arrivals edge%0d got %0d want %0d", i, arrivals, exp_arr); end
            if (presence !== m_pres) begin miscompares++; $display("FAIL gap_presence edge%0d got %b want %b", i, presence, m_pres); end
            if (prev_p === 1'b1 && presence === 1'b0) p_fall = i;
            if (prev_c === 1'b1 && C === 1'b0) c_fall = i;
            prev_p = presence;
            prev_c = C;
        end
        vectors++;
        if (c_fall < 0 || p_fall < 0 || (c_fall - p_fall) != HOLD) begin
            miscompares++;
            $display("FAIL gap_hold_len got %0d (C fall %0d, presence fall %0d) want %0d", c_fall - p_fall, c_fall, p_fall, HOLD);
        end
    endtask

    task automatic pulse(input int sg_at);
        for (int i = 0; i < 16; i++) begin
            step(i < 6, (i == sg_at), 1'b1);
            vectors += 2;
            if (arrivals !== CNT_W'(m_arr)) begin miscompares++; $display("FAIL pulse_arrivals got %0d want %0d", arrivals, m_arr); end
            if (arrivals2 !== CNT_W2'(m_arr2)) begin miscompares++; $display("FAIL pulse_arrivals2 got %0d want %0d", arrivals2, m_arr2); end
        end
    endtask

    task automatic test_sg_clear_saturate();
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) pulse(-1);
        vectors++;
        if (arrivals !== CNT_W'(3)) begin miscompares++; $display("FAIL sg_pre_count got %0d want 3", arrivals); end
        pulse(DEB + 1);   // SG lands on the same edge as the new arrival
        vectors += 2;
        if (arrivals !== CNT_W'(1)) begin miscompares++; $display("FAIL sg_clear_count got %0d want 1", arrivals); end
        if (arrivals2 !== CNT_W2'(1)) begin miscompares++; $display("FAIL sg_clear_count2 got %0d want 1", arrivals2); end
        for (int k = 0; k < 5; k++) pulse(-1);
        vectors += 2;
        if (arrivals !== CNT_W'(6)) begin miscompares++; $display("FAIL sat_count8 got %0d want 6", arrivals); end
        if (arrivals2 !== CNT_W2'(3)) begin miscompares++; $display("FAIL sat_count2 got %0d want 3", arrivals2); end
    endtask

    task automatic test_reset_mid_hold();
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(i < 8, 1'b0, 1'b1);
        vectors++;
        if (C !== 1'b1) begin miscompares++; $display("FAIL midhold_pre_C got %b want 1", C); end
        step(1'b0, 1'b0, 1'b0);
        vectors += 2;
        if (C !== 1'b0) begin miscompares++; $display("FAIL midhold_reset_C got %b want 0", C); end
        if (presence !== 1'b0) begin miscompares++; $display("FAIL midhold_reset_presence got %b want 0", presence); end
    endtask

    task automatic test_random();
        bit raw, sg, rst;
        int run;
        run = 0;
        raw = 0;
        for (int i = 0; i < 800; i++) begin
            if (run == 0) begin
                raw = $urandom_range(0, 1);
                run = $urandom_range(1, 8);
            end
            run--;
            sg  = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) != 0);
            step(raw, sg, rst);
            vectors += 5;
            if (C !== m_c) begin miscompares++; $display("FAIL rand_C cyc%0d got %b want %b", i, C, m_c); end
            if (presence !== m_pres) begin miscompares++; $display("FAIL rand_presence cyc%0d got %b want %b", i, presence, m_pres); end
            if (arrivals !== CNT_W'(m_arr)) begin miscompares++; $display("FAIL rand_arrivals cyc%0d got %0d want %0d", i, arrivals, m_arr); end
            if (arrivals2 !== CNT_W2'(m_arr2)) begin miscompares++; $display("FAIL rand_arrivals2 cyc%0d got %0d want %0d", i, arrivals2, m_arr2); end
            if (stuck !== 1'b0) begin miscompares++; $display("FAIL rand_stuck cyc%0d got %b want 0", i, stuck); end
        end
    endtask

    initial begin
        m_edge = 0;
        model_edge(1'b0, 1'b0, 1'b0);
        test_reset();
        test_first_arrival();
        test_glitch();
        test_gap();
        test_sg_clear_saturate();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
